// File: rtl/fcsr_pkg.sv
// Shared constants and types for the floating-point CSR unit:
// CSR addresses, access opcodes, FSM states and rounding-mode codes.
package fcsr_pkg;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        OP_ILL = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RM_RNE  = 3'b000,
        RM_RTZ  = 3'b001,
        RM_RDN  = 3'b010,
        RM_RUP  = 3'b011,
        RM_RMM  = 3'b100,
        RM_RSV5 = 3'b101,
        RM_RSV6 = 3'b110,
        RM_DYN  = 3'b111
    } rm_e;

    // Codes 101/110 are reserved; 111 is only meaningful as a dynamic selector.
    function automatic logic rm_reserved(input logic [2:0] rm);
        return (rm == RM_RSV5) || (rm == RM_RSV6) || (rm == RM_DYN);
    endfunction

endpackage

// File: rtl/fcsr_rm_resolve.sv
// Resolves the effective rounding mode of an FPU instruction against the
// dynamic frm register and flags reserved results.
module fcsr_rm_resolve
    import fcsr_pkg::*;
(
    input  logic [2:0] frm,
    input  logic [2:0] fpu_rm,
    output logic [2:0] rm_resolved,
    output logic       rm_invalid
);

    always_comb begin
        rm_resolved = (fpu_rm == RM_DYN) ? frm : fpu_rm;
        rm_invalid  = rm_reserved(rm_resolved);
    end

endmodule

// File: rtl/fcsr_csr_unit.sv
// Floating-point CSR unit: fflags/frm/fcsr read-modify-write access via a
// three-state handshake, plus sticky accumulation of retiring FPU flags.
module fcsr_csr_unit
    import fcsr_pkg::*;
#(
    parameter logic [11:0] FFLAGS_ADDR = CSR_FFLAGS,
    parameter logic [11:0] FRM_ADDR    = CSR_FRM,
    parameter logic [11:0] FCSR_ADDR   = CSR_FCSR
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        csr_req,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        csr_ack,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_flags,
    input  logic [2:0]  fpu_rm,
    output logic [2:0]  rm_resolved,
    output logic        rm_invalid,
    output logic [2:0]  frm,
    output logic [4:0]  fflags
);

    state_e      state;
    csr_op_e     op_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;

    logic       sel_fflags;
    logic       sel_frm;
    logic       sel_fcsr;
    logic       illegal;
    logic       wr_en;
    logic [7:0] old_val;
    logic [7:0] new_val;
    logic [4:0] acc_flags;

    fcsr_rm_resolve u_rm_resolve (
        .frm         (frm),
        .fpu_rm      (fpu_rm),
        .rm_resolved (rm_resolved),
        .rm_invalid  (rm_invalid)
    );

    always_comb begin
        sel_fflags = (addr_q == FFLAGS_ADDR);
        sel_frm    = (addr_q == FRM_ADDR);
        sel_fcsr   = (addr_q == FCSR_ADDR);
        illegal    = (op_q == OP_ILL) || !(sel_fflags || sel_frm || sel_fcsr);

        old_val = '0;
        if (sel_fflags)
            old_val = {3'b000, fflags};
        else if (sel_frm)
            old_val = {5'b00000, frm};
        else if (sel_fcsr)
            old_val = {frm, fflags};

        // Only the low byte can ever reach a field; zero-test uses the full operand.
        unique case (op_q)
            OP_RW:   new_val = wdata_q[7:0];
            OP_RS:   new_val = old_val | wdata_q[7:0];
            OP_RC:   new_val = old_val & ~wdata_q[7:0];
            default: new_val = old_val;
        endcase

        wr_en     = !illegal && ((op_q == OP_RW) || (wdata_q != '0));
        acc_flags = fpu_valid ? fpu_flags : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_ILL;
            addr_q      <= '0;
            wdata_q     <= '0;
            frm         <= '0;
            fflags      <= '0;
            csr_ack     <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
        end else begin
            csr_ack     <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
            fflags      <= fflags | acc_flags;

            unique case (state)
                ST_IDLE: begin
                    if (csr_req) begin
                        op_q    <= csr_op_e'(csr_op);
                        addr_q  <= csr_addr;
                        wdata_q <= csr_wdata;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state       <= ST_RESP;
                    csr_ack     <= 1'b1;
                    csr_illegal <= illegal;
                    csr_rdata   <= illegal ? '0 : {24'b0, old_val};
                    // A colliding FPU retirement still contributes its flags.
                    if (wr_en) begin
                        if (sel_fflags)
                            fflags <= new_val[4:0] | acc_flags;
                        else if (sel_frm)
                            frm <= new_val[2:0];
                        else if (sel_fcsr) begin
                            frm    <= new_val[7:5];
                            fflags <= new_val[4:0] | acc_flags;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcsr_csr_unit.sv
// Self-checking bench for fcsr_csr_unit: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_fcsr_csr_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        fpu_valid;
    logic [4:0]  fpu_flags;
    logic [2:0]  fpu_rm;
    logic [2:0]  rm_resolved;
    logic        rm_invalid;
    logic [2:0]  frm;
    logic [4:0]  fflags;

    int n_checks = 0;
    int n_errors = 0;

    fcsr_csr_unit #(
        .FFLAGS_ADDR (12'h001),
        .FRM_ADDR    (12'h002),
        .FCSR_ADDR   (12'h003)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .csr_req     (csr_req),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_ack     (csr_ack),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .fpu_valid   (fpu_valid),
        .fpu_flags   (fpu_flags),
        .fpu_rm      (fpu_rm),
        .rm_resolved (rm_resolved),
        .rm_invalid  (rm_invalid),
        .frm         (frm),
        .fflags      (fflags)
    );

    always #5 clock = ~clock;

    // Reference model: architectural registers plus the one outstanding access.
    int          m_frm, m_fflags;
    int          m_wait;          // edges left before the pending access executes; -1 none
    int          m_cool;          // edges left in the response cycle
    int          p_op, p_addr;
    int unsigned p_wdata;
    int          e_ack, e_illegal;
    int unsigned e_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int unsigned oldv, newv, flags_in;
        flags_in = fpu_valid ? fpu_flags : 0;
        e_ack = 0; e_rdata = 0; e_illegal = 0;
        if (reset) begin
            m_frm = 0; m_fflags = 0; m_wait = -1; m_cool = 0;
            return;
        end
        if (m_wait == 0) begin
            m_wait = -1;
            m_cool = 1;
            e_ack  = 1;
            if (p_op == 0 || p_addr < 1 || p_addr > 3) begin
                e_illegal = 1;
                m_fflags = m_fflags | flags_in;
            end else begin
                oldv = (p_addr == 1) ? m_fflags : (p_addr == 2) ? m_frm : m_frm * 32 + m_fflags;
                e_rdata = oldv;
                if (p_op == 1)      newv = p_wdata;
                else if (p_op == 2) newv = oldv | p_wdata;
                else                newv = oldv & ~p_wdata;
                if (p_op == 1 || p_wdata != 0) begin
                    if (p_addr == 2) begin
                        m_frm = newv % 8;
                        m_fflags = m_fflags | flags_in;
                    end else begin
                        if (p_addr == 3) m_frm = (newv / 32) % 8;
                        m_fflags = (newv % 32) | flags_in;
                    end
                end else
                    m_fflags = m_fflags | flags_in;
            end
            return;
        end
        m_fflags = m_fflags | flags_in;
        if (m_wait > 0) begin
            m_wait--;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (csr_req) begin
            p_op = csr_op; p_addr = csr_addr; p_wdata = csr_wdata;
            m_wait = 0;
        end
    endtask

    task automatic check_comb();
        int exp_rm;
        exp_rm = (fpu_rm == 7) ? m_frm : fpu_rm;
        check("rm_resolved", rm_resolved, exp_rm);
        check("rm_invalid", rm_invalid, (exp_rm >= 5) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("ack", csr_ack, e_ack);
        check("rdata", csr_rdata, e_rdata);
        check("illegal", csr_illegal, e_illegal);
        check("frm", frm, m_frm);
        check("fflags", fflags, m_fflags);
        check_comb();
    endtask

    logic        g_ack, g_ill;
    logic [31:0] g_rdata;

    // One complete access; the FPU inputs given apply during the execute cycle.
    task automatic access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                          input logic fv, input logic [4:0] ff);
        csr_req = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd;
        tick();
        // A stray request while busy must be ignored.
        csr_op = 2'b01; csr_addr = 12'h002; csr_wdata = 32'h7;
        fpu_valid = fv; fpu_flags = ff;
        tick();
        g_ack = csr_ack; g_rdata = csr_rdata; g_ill = csr_illegal;
        csr_req = 1'b0; fpu_valid = 1'b0; fpu_flags = '0;
        tick();
        check("ack_drop", csr_ack, 1'b0);
    endtask

    initial begin
        reset = 1'b1; csr_req = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0;
        fpu_valid = 1'b0; fpu_flags = '0; fpu_rm = 3'b000;
        m_wait = -1; m_cool = 0; m_frm = 0; m_fflags = 0;
        tick(); tick();
        check("rst_frm", frm, 3'b000);
        check("rst_fflags", fflags, 5'b00000);
        check("rst_ack", csr_ack, 1'b0);
        reset = 1'b0;
        tick();

        access(2'b01, 12'h003, 32'h0000_00E5, 1'b0, 5'b0);
        check("d1_ack", g_ack, 1'b1);
        check("d1_rdata", g_rdata, 32'h0);
        check("d1_frm", frm, 3'b111);
        check("d1_fflags", fflags, 5'b00101);

        access(2'b01, 12'h001, 32'h1, 1'b0, 5'b0);
        access(2'b10, 12'h001, 32'h10, 1'b0, 5'b0);
        check("d2_rdata", g_rdata, 32'h01);
        check("d2_fflags", fflags, 5'b10001);
        access(2'b11, 12'h001, 32'h0, 1'b0, 5'b0);
        check("d2_rc0_fflags", fflags, 5'b10001);
        access(2'b11, 12'h001, 32'h1, 1'b0, 5'b0);
        check("d2_rc_fflags", fflags, 5'b10000);

        access(2'b01, 12'h001, 32'h02, 1'b1, 5'b00100);
        check("d3_rdata", g_rdata, 32'h10);
        check("d3_fflags", fflags, 5'b00110);

        access(2'b01, 12'h004, 32'hFF, 1'b0, 5'b0);
        check("d4_ack", g_ack, 1'b1);
        check("d4_illegal", g_ill, 1'b1);
        check("d4_rdata", g_rdata, 32'h0);
        check("d4_frm", frm, 3'b111);
        check("d4_fflags", fflags, 5'b00110);
        access(2'b00, 12'h001, 32'h1F, 1'b0, 5'b0);
        check("d4_op00_illegal", g_ill, 1'b1);
        check("d4_op00_fflags", fflags, 5'b00110);

        access(2'b01, 12'h002, 32'h2, 1'b0, 5'b0);
        fpu_rm = 3'b111; #1;
        check("d5_rm_dyn", rm_resolved, 3'b010);
        check("d5_inv0", rm_invalid, 1'b0);
        access(2'b01, 12'h002, 32'h5, 1'b0, 5'b0);
        check("d5_frm_rsv", frm, 3'b101);
        check("d5_inv1", rm_invalid, 1'b1);
        fpu_rm = 3'b001; #1;
        check("d5_rm_static", rm_resolved, 3'b001);
        check("d5_inv_static", rm_invalid, 1'b0);

        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h002; csr_wdata = 32'h3;
        tick();
        csr_req = 1'b0; reset = 1'b1;
        tick();
        check("d6_ack", csr_ack, 1'b0);
        check("d6_frm", frm, 3'b000);
        reset = 1'b0;
        tick();
        check("d6_ack_after", csr_ack, 1'b0);
        access(2'b01, 12'h002, 32'h1, 1'b0, 5'b0);
        check("d6_next_ack", g_ack, 1'b1);
        check("d6_next_rdata", g_rdata, 32'h0);
        check("d6_next_frm", frm, 3'b001);

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 79) == 0);
            csr_req   = ($urandom_range(0, 2) == 0);
            csr_op    = 2'($urandom);
            case ($urandom_range(0, 4))
                0: csr_addr = 12'h001;
                1: csr_addr = 12'h002;
                2: csr_addr = 12'h003;
                3: csr_addr = 12'($urandom);
                default: csr_addr = 12'($urandom_range(0, 5));
            endcase
            csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            fpu_valid = ($urandom_range(0, 2) == 0);
            fpu_flags = 5'($urandom);
            fpu_rm    = 3'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
